// File: rtl/neuron_mac_node.sv
// Neuron compute node: accumulates activation x weight products over a
// programmed fan-in, adds the bias, applies optional ReLU, saturates to Q8.8
// and hands the result back to the layer controller with a done pulse.
module neuron_mac_node #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FRAC   = 8,
   parameter int unsigned ACC_W  = 40,
   parameter int unsigned LEN_W  = 10
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              head_c2node,
   input  logic              data_select_c2node,
   input  logic              relu_en_c2node,
   input  logic [LEN_W-1:0]  len_c2node,
   input  logic [DATA_W-1:0] b_data,
   input  logic [DATA_W-1:0] x_data,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] w_data,
   input  logic              in_valid,
   output logic              busy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              done_flag_node2c,
   output logic              sat_flag
);

   localparam int unsigned PROD_W   = 2 * DATA_W;
   localparam int unsigned RES_W    = ACC_W - FRAC;
   localparam int unsigned PROD_PAD = ACC_W - PROD_W;
   localparam int unsigned BIAS_PAD = ACC_W - DATA_W - FRAC;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACCUM = 3'd1,
      S_BIAS  = 3'd2,
      S_ACT   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state;
   state_t state_nx;

   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  count;
   logic              sel_q;
   logic              relu_q;
   logic [DATA_W-1:0] bias_q;
   logic [ACC_W-1:0]  acc;

   logic              head_ok;
   logic              beat;
   logic              last_beat;

   logic signed [DATA_W-1:0] op_s;
   logic signed [DATA_W-1:0] w_s;
   logic signed [PROD_W-1:0] prod;
   logic [ACC_W-1:0]         prod_ext;
   logic [ACC_W-1:0]         bias_ext;
   logic [RES_W-1:0]         r_shift;
   logic [RES_W-1:0]         r_act;
   logic                     res_fits;
   logic [DATA_W-1:0]        res;
   logic                     res_sat;

   logic busy_nx;
   logic valid_nx;

   assign head_ok   = (state == S_IDLE) && head_c2node;
   assign beat      = (state == S_ACCUM) && in_valid;
   assign last_beat = beat && (count == len_q - LEN_W'(1));

   // State register; a low rst aborts any job in flight.
   always_ff @(posedge clock) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state sequencing through accumulate, bias, activation and done.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (head_c2node) state_nx = (len_c2node != '0) ? S_ACCUM : S_BIAS;
         S_ACCUM: if (last_beat)   state_nx = S_BIAS;
         S_BIAS:  state_nx = S_ACT;
         S_ACT:   state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the flags are registered.
   always_comb begin
      busy_nx  = (state_nx != S_IDLE);
      valid_nx = (state_nx == S_DONE);
   end

   // Product, bias alignment and Q8.8 activation/saturation of the accumulator.
   always_comb begin
      op_s     = sel_q ? a_data : x_data;
      w_s      = w_data;
      prod     = PROD_W'(op_s) * PROD_W'(w_s);
      prod_ext = {{PROD_PAD{prod[PROD_W-1]}}, prod};
      bias_ext = {{BIAS_PAD{bias_q[DATA_W-1]}}, bias_q, {FRAC{1'b0}}};
      r_shift  = acc[ACC_W-1:FRAC];
      r_act    = (relu_q && r_shift[RES_W-1]) ? '0 : r_shift;
      // Fits in DATA_W when all bits from the DATA_W sign bit upward agree.
      res_fits = (&r_act[RES_W-1:DATA_W-1]) || !(|r_act[RES_W-1:DATA_W-1]);
      res_sat  = !res_fits;
      if (res_fits)              res = r_act[DATA_W-1:0];
      else if (r_act[RES_W-1])   res = {1'b1, {(DATA_W-1){1'b0}}};
      else                       res = {1'b0, {(DATA_W-1){1'b1}}};
   end

   // Job parameters, accumulator and beat counter.
   always_ff @(posedge clock) begin
      if (!rst) begin
         len_q  <= '0;
         sel_q  <= 1'b0;
         relu_q <= 1'b0;
         bias_q <= '0;
         acc    <= '0;
         count  <= '0;
      end else begin
         if (head_ok) begin
            len_q  <= len_c2node;
            sel_q  <= data_select_c2node;
            relu_q <= relu_en_c2node;
            bias_q <= b_data;
            acc    <= '0;
            count  <= '0;
         end else if (beat) begin
            acc   <= acc + prod_ext;
            count <= count + LEN_W'(1);
         end else if (state == S_BIAS) begin
            acc <= acc + bias_ext;
         end
      end
   end

   // Registered result, saturation flag and handshake outputs.
   always_ff @(posedge clock) begin
      if (!rst) begin
         out_data         <= '0;
         sat_flag         <= 1'b0;
         busy             <= 1'b0;
         out_valid        <= 1'b0;
         done_flag_node2c <= 1'b0;
      end else begin
         busy             <= busy_nx;
         out_valid        <= valid_nx;
         done_flag_node2c <= valid_nx;
         if (head_ok) begin
            sat_flag <= 1'b0;
         end else if (state == S_ACT) begin
            out_data <= res;
            sat_flag <= res_sat;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac_node.sv
// Scoreboard bench for neuron_mac_node: expected results are queued when a
// job is launched and popped when the node raises out_valid.
module tb_neuron_mac_node;

   typedef struct {
      logic [15:0] data;
      logic        sat;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst;
   logic        head_c2node;
   logic        data_select_c2node;
   logic        relu_en_c2node;
   logic [9:0]  len_c2node;
   logic [15:0] b_data;
   logic [15:0] x_data;
   logic [15:0] a_data;
   logic [15:0] w_data;
   logic        in_valid;
   logic        busy;
   logic [15:0] out_data;
   logic        out_valid;
   logic        done_flag_node2c;
   logic        sat_flag;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   exp_t        sb[$];
   bit          beat_v[$];
   logic [15:0] beat_x[$];
   logic [15:0] beat_a[$];
   logic [15:0] beat_w[$];

   neuron_mac_node dut (
      .clock              (clock),
      .rst                (rst),
      .head_c2node        (head_c2node),
      .data_select_c2node (data_select_c2node),
      .relu_en_c2node     (relu_en_c2node),
      .len_c2node         (len_c2node),
      .b_data             (b_data),
      .x_data             (x_data),
      .a_data             (a_data),
      .w_data             (w_data),
      .in_valid           (in_valid),
      .busy               (busy),
      .out_data           (out_data),
      .out_valid          (out_valid),
      .done_flag_node2c   (done_flag_node2c),
      .sat_flag           (sat_flag)
   );

   always #5 clock = ~clock;

   // Count done pulses on the active edge (sees the pre-edge value).
   always @(posedge clock) if (done_flag_node2c === 1'b1) done_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_beats();
      beat_v.delete(); beat_x.delete(); beat_a.delete(); beat_w.delete();
   endtask

   task automatic add_beat(input bit v, input logic [15:0] x, input logic [15:0] a,
                           input logic [15:0] w);
      beat_v.push_back(v); beat_x.push_back(x); beat_a.push_back(a); beat_w.push_back(w);
   endtask

   // Reference: wide integer arithmetic, floor shift, ReLU, then clamp.
   function automatic exp_t model(input logic sel, input logic relu, input logic [15:0] b);
      exp_t   e;
      longint sum;
      longint r;
      logic [15:0] op;
      sum = 0;
      foreach (beat_v[i]) begin
         if (beat_v[i]) begin
            op  = sel ? beat_a[i] : beat_x[i];
            sum = sum + longint'($signed(op)) * longint'($signed(beat_w[i]));
         end
      end
      sum = sum + longint'($signed(b)) * 256;
      r = sum >>> 8;
      if (relu && r < 0) r = 0;
      e.sat = 1'b0;
      if (r > 32767) begin
         e.data = 16'h7FFF; e.sat = 1'b1;
      end else if (r < -32768) begin
         e.data = 16'h8000; e.sat = 1'b1;
      end else begin
         e.data = 16'(r);
      end
      return e;
   endfunction

   // Step negedges until out_valid, bounded; n counts negedges taken.
   task automatic wait_result(output int n, output bit got);
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clock);
         n++;
         head_c2node = 1'b0;
         in_valid    = 1'b0;
         b_data      = 16'($urandom);
         if (out_valid === 1'b1) got = 1'b1;
      end
   endtask

   // Launch one job from the current negedge using the beat queues.
   task automatic run_job(input string name, input logic [9:0] len, input logic sel,
                          input logic relu, input logic [15:0] b,
                          input bit head_at_done, input logic [15:0] b2);
      exp_t e;
      exp_t exp_v;
      int   n;
      bit   got;
      e = model(sel, relu, b);
      sb.push_back(e);
      head_c2node        = 1'b1;
      len_c2node         = len;
      data_select_c2node = sel;
      relu_en_c2node     = relu;
      b_data             = b;
      if (beat_v.size() != 0) begin
         @(negedge clock);
         head_c2node = 1'b0;
         b_data      = 16'($urandom);
         n_cmp++;
         if (busy !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_after_head: got %b expected 1", name, busy);
         end
         n_cmp++;
         if (sat_flag !== 1'b0) begin
            n_bad++; $display("FAIL %s sat_clear_at_head: got %b expected 0", name, sat_flag);
         end
         foreach (beat_v[i]) begin
            in_valid = beat_v[i];
            x_data   = beat_x[i];
            a_data   = beat_a[i];
            w_data   = beat_w[i];
            if (i != beat_v.size() - 1) @(negedge clock);
         end
      end
      wait_result(n, got);
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL %s timeout: no out_valid within %0d cycles", name, n);
         void'(sb.pop_front());
         return;
      end
      exp_v = sb.pop_front();
      n_cmp++;
      if (out_data !== exp_v.data) begin
         n_bad++; $display("FAIL %s out_data: got %h expected %h", name, out_data, exp_v.data);
      end
      n_cmp++;
      if (sat_flag !== exp_v.sat) begin
         n_bad++; $display("FAIL %s sat_flag: got %b expected %b", name, sat_flag, exp_v.sat);
      end
      n_cmp++;
      if (done_flag_node2c !== 1'b1) begin
         n_bad++; $display("FAIL %s done_flag: got %b expected 1", name, done_flag_node2c);
      end
      n_cmp++;
      if (n != 3) begin
         n_bad++; $display("FAIL %s latency: got %0d expected 3", name, n);
      end
      if (head_at_done) begin
         head_c2node = 1'b1;
         len_c2node  = 10'd0;
         b_data      = b2;
      end
      @(negedge clock);
      head_c2node = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || done_flag_node2c !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s pulse_end: got valid=%b done=%b busy=%b expected 0 0 0",
                  name, out_valid, done_flag_node2c, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clock);
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done_flag_node2c !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got busy=%b valid=%b done=%b expected 0 0 0",
                  busy, out_valid, done_flag_node2c);
      end
      n_cmp++;
      if (out_data !== 16'h0000 || sat_flag !== 1'b0) begin
         n_bad++; $display("FAIL reset_data: got %h sat=%b expected 0000 0", out_data, sat_flag);
      end
      rst = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic_mac();
      clear_beats();
      add_beat(1, 16'h0100, 16'h0000, 16'h0100);
      add_beat(1, 16'h0200, 16'h0000, 16'h0100);
      add_beat(1, 16'h0300, 16'h0000, 16'h0100);
      run_job("basic_mac", 10'd3, 1'b0, 1'b0, 16'h0100, 1'b0, 16'h0);
   endtask

   task automatic test_gapped_select();
      clear_beats();
      add_beat(1, 16'($urandom), 16'h0100, 16'h0100);
      add_beat(0, 16'($urandom), 16'($urandom), 16'($urandom));
      add_beat(1, 16'($urandom), 16'h0200, 16'h0100);
      add_beat(0, 16'($urandom), 16'($urandom), 16'($urandom));
      add_beat(1, 16'($urandom), 16'h0300, 16'h0100);
      run_job("gapped_select", 10'd3, 1'b1, 1'b0, 16'h0100, 1'b0, 16'h0);
   endtask

   task automatic test_relu();
      clear_beats();
      add_beat(1, 16'h0000, 16'h0100, 16'hFE00);
      run_job("relu_on", 10'd1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0);
      run_job("relu_off", 10'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0);
   endtask

   task automatic test_saturation();
      clear_beats();
      add_beat(1, 16'h7FFF, 16'h0000, 16'h7FFF);
      add_beat(1, 16'h7FFF, 16'h0000, 16'h7FFF);
      run_job("sat_pos", 10'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0);
      clear_beats();
      add_beat(1, 16'h7FFF, 16'h0000, 16'h8000);
      add_beat(1, 16'h7FFF, 16'h0000, 16'h8000);
      run_job("sat_neg", 10'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0);
      clear_beats();
      add_beat(1, 16'h0080, 16'h0000, 16'h0200);
      run_job("sat_cleared", 10'd1, 1'b0, 1'b0, 16'h0040, 1'b0, 16'h0);
   endtask

   task automatic test_len0_ignored_head();
      int   d0;
      exp_t e;
      int   n;
      bit   got;
      clear_beats();
      run_job("len0", 10'd0, 1'b0, 1'b0, 16'h0180, 1'b0, 16'h0);
      // Second head while the node is in BIAS must not restart or relatch.
      d0 = done_cnt;
      e = model(1'b0, 1'b0, 16'h0180);
      sb.push_back(e);
      head_c2node = 1'b1; len_c2node = 10'd0; b_data = 16'h0180;
      @(negedge clock);
      head_c2node = 1'b1; len_c2node = 10'd2; b_data = 16'h0500;
      @(negedge clock);
      head_c2node = 1'b0;
      b_data = 16'h0000;
      wait_result(n, got);
      n_cmp++;
      if (!got) begin
         n_bad++; $display("FAIL ignored_head timeout: no out_valid within %0d cycles", n);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if (out_data !== e.data) begin
            n_bad++; $display("FAIL ignored_head out_data: got %h expected %h", out_data, e.data);
         end
      end
      repeat (6) @(negedge clock);
      n_cmp++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL ignored_head pulses: got %0d busy=%b expected 1 busy=0",
                  done_cnt - d0, busy);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      clear_beats();
      run_job("done_head", 10'd0, 1'b0, 1'b0, 16'h0100, 1'b1, 16'h0300);
      d0 = done_cnt;
      repeat (5) @(negedge clock);
      n_cmp++;
      if (done_cnt != d0 || busy !== 1'b0 || out_data !== 16'h0100) begin
         n_bad++;
         $display("FAIL head_in_done_ignored: got pulses=%0d busy=%b data=%h expected 0 0 0100",
                  done_cnt - d0, busy, out_data);
      end
      add_beat(1, 16'h0100, 16'h0000, 16'h0300);
      run_job("b2b_first", 10'd1, 1'b0, 1'b0, 16'hFF00, 1'b0, 16'h0);
      run_job("b2b_second", 10'd1, 1'b0, 1'b1, 16'hFA00, 1'b0, 16'h0);
   endtask

   task automatic test_reset_mid_accum();
      int d0;
      clear_beats();
      head_c2node = 1'b1; len_c2node = 10'd5; data_select_c2node = 1'b0;
      relu_en_c2node = 1'b0; b_data = 16'h0100;
      @(negedge clock);
      head_c2node = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; x_data = 16'h0100; w_data = 16'h0200;
         @(negedge clock);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      d0 = done_cnt;
      @(negedge clock);
      rst = 1'b1;
      n_cmp++;
      if (busy !== 1'b0 || out_data !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_mid_accum: got busy=%b data=%h expected 0 0000", busy, out_data);
      end
      repeat (6) @(negedge clock);
      n_cmp++;
      if (done_cnt != d0) begin
         n_bad++; $display("FAIL reset_no_done: got %0d pulses expected 0", done_cnt - d0);
      end
      add_beat(1, 16'h0000, 16'h0180, 16'h0200);
      run_job("after_reset", 10'd1, 1'b1, 1'b0, 16'h0020, 1'b0, 16'h0);
   endtask

   initial begin
      rst = 1'b0; head_c2node = 1'b0; data_select_c2node = 1'b0; relu_en_c2node = 1'b0;
      len_c2node = '0; b_data = '0; x_data = '0; a_data = '0; w_data = '0; in_valid = 1'b0;
      @(negedge clock);
      test_reset();
      test_basic_mac();
      test_gapped_select();
      test_relu();
      test_saturation();
      test_len0_ignored_head();
      test_back_to_back();
      test_reset_mid_accum();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
